// File: rtl/wbu_commit_stage_pkg.sv
// Shared definitions for the write-back/commit stage.
//
// Contents:
//   ST_*           FSM state encoding (BOOT, IDLE, COMMIT, REDIRECT)
//   CSR_*          compressed machine-mode CSR indices
//   MCAUSE_ECALL_M mcause value written by an M-mode ecall
//   MSTATUS_RESET  mstatus value after reset (MPP = M)

package wbu_commit_stage_pkg;

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MTVEC   = 2'd1;
  localparam logic [1:0] CSR_MEPC    = 2'd2;
  localparam logic [1:0] CSR_MCAUSE  = 2'd3;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] MSTATUS_RESET  = 32'h0000_1800;

endpackage

// File: rtl/wbu_csr_file.sv
// Machine-mode CSR file: mstatus, mtvec, mepc, mcause.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   raddr / rdata   combinational read port
//   wen/waddr/wdata general CSR write port
//   trap_wen        ecall side effect: mepc <= trap_epc, mcause <= 11
//   trap_epc        PC of the trapping instruction
//   mtvec, mepc     direct views used for next-PC selection

import wbu_commit_stage_pkg::*;

module wbu_csr_file #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          trap_wen,
  input  logic [31:0]   trap_epc,
  output logic [31:0]   mtvec,
  output logic [31:0]   mepc
);

  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  // The trap write is placed after the general write so that, when both
  // target mepc/mcause, the trap values win; other indices keep the
  // general write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= MSTATUS_RESET;
      mtvec_q   <= 32'd0;
      mepc_q    <= 32'd0;
      mcause_q  <= 32'd0;
    end else begin
      if (wen) begin
        if (waddr == AW'(CSR_MSTATUS)) mstatus_q <= wdata;
        if (waddr == AW'(CSR_MTVEC))   mtvec_q   <= wdata;
        if (waddr == AW'(CSR_MEPC))    mepc_q    <= wdata;
        if (waddr == AW'(CSR_MCAUSE))  mcause_q  <= wdata;
      end
      if (trap_wen) begin
        mepc_q   <= trap_epc;
        mcause_q <= MCAUSE_ECALL_M;
      end
    end
  end

  always_comb begin
    rdata = mstatus_q;
    if (raddr == AW'(CSR_MTVEC))  rdata = mtvec_q;
    if (raddr == AW'(CSR_MEPC))   rdata = mepc_q;
    if (raddr == AW'(CSR_MCAUSE)) rdata = mcause_q;
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: rtl/wbu_commit_stage.sv
// Write-back/commit stage. Accepts one retired instruction from the LSU,
// commits its register-file and CSR writes, then offers the next PC to
// fetch on a valid/ready redirect channel.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           instruction handshake from the LSU
//   pc_in ... fence_i_in        retired-instruction fields
//   rf_wen/rf_waddr/rf_wdata    register-file write (one cycle, COMMIT)
//   csr_raddr/csr_rdata         combinational CSR read for the EXU
//   npc_valid/npc_ready/npc     next-PC handshake to fetch
//   npc_flush                   I-cache invalidate, qualified by npc_valid
//
// Optional build macro WBU_INSTRET_EN adds:
//   instret      64-bit retired-instruction counter
//   commit_pulse high during the COMMIT cycle

import wbu_commit_stage_pkg::*;

module wbu_commit_stage #(
  parameter int          REG_AW   = 4,
  parameter int          CSR_AW   = 2,
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       result_in,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              csr_write_in,
  input  logic [CSR_AW-1:0] csr_addr_in,
  input  logic              ecall_in,
  input  logic              mret_in,
  input  logic              is_branch_in,
  input  logic [31:0]       branch_target_in,
  input  logic              fence_i_in,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  input  logic [CSR_AW-1:0] csr_raddr,
  output logic [31:0]       csr_rdata,
  output logic              npc_valid,
  input  logic              npc_ready,
  output logic [31:0]       npc,
`ifdef WBU_INSTRET_EN
  output logic [63:0]       instret,
  output logic              commit_pulse,
`endif
  output logic              npc_flush
);

  logic [1:0]        state;
  logic [31:0]       lat_pc;
  logic [31:0]       lat_result;
  logic              lat_reg_write;
  logic [REG_AW-1:0] lat_rd;
  logic              lat_csr_write;
  logic [CSR_AW-1:0] lat_csr_addr;
  logic              lat_ecall;
  logic              lat_mret;
  logic              lat_branch;
  logic [31:0]       lat_target;
  logic              lat_fence_i;
  logic [31:0]       npc_q;
  logic [31:0]       next_npc;
  logic [31:0]       mtvec;
  logic [31:0]       mepc;
  logic              in_commit;

  assign in_commit = (state == ST_COMMIT);

  // Next-PC priority: ecall > mret > taken branch > sequential. The CSR
  // values seen here are the ones before the COMMIT-cycle update.
  always_comb begin
    next_npc = lat_pc + 32'd4;
    if (lat_ecall)       next_npc = mtvec;
    else if (lat_mret)   next_npc = mepc;
    else if (lat_branch) next_npc = lat_target;
  end

  // Main FSM plus the instruction latch. npc_q holds RESET_PC through
  // BOOT and the computed target through REDIRECT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BOOT;
      lat_pc        <= 32'd0;
      lat_result    <= 32'd0;
      lat_reg_write <= 1'b0;
      lat_rd        <= '0;
      lat_csr_write <= 1'b0;
      lat_csr_addr  <= '0;
      lat_ecall     <= 1'b0;
      lat_mret      <= 1'b0;
      lat_branch    <= 1'b0;
      lat_target    <= 32'd0;
      lat_fence_i   <= 1'b0;
      npc_q         <= RESET_PC;
    end else begin
      case (state)
        ST_BOOT: begin
          if (npc_ready) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (in_valid) begin
            lat_pc        <= pc_in;
            lat_result    <= result_in;
            lat_reg_write <= reg_write_in;
            lat_rd        <= rd_in;
            lat_csr_write <= csr_write_in;
            lat_csr_addr  <= csr_addr_in;
            lat_ecall     <= ecall_in;
            lat_mret      <= mret_in;
            lat_branch    <= is_branch_in;
            lat_target    <= branch_target_in;
            lat_fence_i   <= fence_i_in;
            state         <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          npc_q <= next_npc;
          state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (npc_ready) state <= ST_IDLE;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  // The rf strobe is gated by rst so a reset landing in COMMIT drops the
  // write combinationally, matching the discarded CSR update.
  assign rf_wen    = in_commit && lat_reg_write && (lat_rd != '0) && !rst;
  assign rf_waddr  = lat_rd;
  assign rf_wdata  = lat_result;
  assign in_ready  = (state == ST_IDLE);
  assign npc_valid = (state == ST_BOOT) || (state == ST_REDIRECT);
  assign npc       = npc_q;
  assign npc_flush = (state == ST_REDIRECT) && lat_fence_i;

  wbu_csr_file #(.AW(CSR_AW)) u_csr (
    .clk      (clk),
    .rst      (rst),
    .raddr    (csr_raddr),
    .rdata    (csr_rdata),
    .wen      (in_commit && lat_csr_write),
    .waddr    (lat_csr_addr),
    .wdata    (lat_result),
    .trap_wen (in_commit && lat_ecall),
    .trap_epc (lat_pc),
    .mtvec    (mtvec),
    .mepc     (mepc)
  );

`ifdef WBU_INSTRET_EN
  // Retired-instruction counter; wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) instret <= 64'd0;
    else if (in_commit) instret <= instret + 64'd1;
  end

  assign commit_pulse = in_commit;
`endif

endmodule

// File: tb/tb_wbu_commit_stage.sv
// Self-checking bench for wbu_commit_stage: a table of directed
// instructions followed by hand-written boot, stall and reset sequences.

module tb_wbu_commit_stage;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] result_in;
  logic        reg_write_in;
  logic [3:0]  rd_in;
  logic        csr_write_in;
  logic [1:0]  csr_addr_in;
  logic        ecall_in;
  logic        mret_in;
  logic        is_branch_in;
  logic [31:0] branch_target_in;
  logic        fence_i_in;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  csr_raddr;
  logic [31:0] csr_rdata;
  logic        npc_valid;
  logic        npc_ready;
  logic [31:0] npc;
  logic        npc_flush;
`ifdef WBU_INSTRET_EN
  logic [63:0] instret;
  logic        commit_pulse;
`endif

  int checks = 0;
  int errors = 0;

  wbu_commit_stage #(
    .REG_AW   (4),
    .CSR_AW   (2),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pc_in            (pc_in),
    .result_in        (result_in),
    .reg_write_in     (reg_write_in),
    .rd_in            (rd_in),
    .csr_write_in     (csr_write_in),
    .csr_addr_in      (csr_addr_in),
    .ecall_in         (ecall_in),
    .mret_in          (mret_in),
    .is_branch_in     (is_branch_in),
    .branch_target_in (branch_target_in),
    .fence_i_in       (fence_i_in),
    .rf_wen           (rf_wen),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .csr_raddr        (csr_raddr),
    .csr_rdata        (csr_rdata),
    .npc_valid        (npc_valid),
    .npc_ready        (npc_ready),
    .npc              (npc),
`ifdef WBU_INSTRET_EN
    .instret          (instret),
    .commit_pulse     (commit_pulse),
`endif
    .npc_flush        (npc_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic        reg_write;
    logic [3:0]  rd;
    logic        csr_write;
    logic [1:0]  csr_addr;
    logic        ecall;
    logic        mret;
    logic        is_branch;
    logic [31:0] target;
    logic        fence_i;
    logic        exp_wen;
    logic [3:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_npc;
    logic        exp_flush;
    logic [1:0]  chk_addr;
    logic [31:0] exp_csr;
  } wb_vec_t;

  wb_vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    in_valid         = 1'b0;
    pc_in            = 32'd0;
    result_in        = 32'd0;
    reg_write_in     = 1'b0;
    rd_in            = 4'd0;
    csr_write_in     = 1'b0;
    csr_addr_in      = 2'd0;
    ecall_in         = 1'b0;
    mret_in          = 1'b0;
    is_branch_in     = 1'b0;
    branch_target_in = 32'd0;
    fence_i_in       = 1'b0;
  endtask

  task automatic driveVec(input wb_vec_t v);
    in_valid         = 1'b1;
    pc_in            = v.pc;
    result_in        = v.result;
    reg_write_in     = v.reg_write;
    rd_in            = v.rd;
    csr_write_in     = v.csr_write;
    csr_addr_in      = v.csr_addr;
    ecall_in         = v.ecall;
    mret_in          = v.mret;
    is_branch_in     = v.is_branch;
    branch_target_in = v.target;
    fence_i_in       = v.fence_i;
  endtask

  // Bounded wait for in_ready; an expired budget counts as a failure.
  task automatic waitReady(input string name);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput({name, "_wait_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // One full instruction: accept, COMMIT, REDIRECT handshake, CSR readback.
  task automatic applyStimulus(input int idx, input wb_vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    waitReady(tag);
    driveVec(v);
    tick();
    clearInputs();
    checkOutput({tag, "_rf_wen"}, {31'd0, rf_wen}, {31'd0, v.exp_wen});
    if (v.exp_wen) begin
      checkOutput({tag, "_rf_waddr"}, {28'd0, rf_waddr}, {28'd0, v.exp_waddr});
      checkOutput({tag, "_rf_wdata"}, rf_wdata, v.exp_wdata);
    end
    checkOutput({tag, "_commit_in_ready"}, {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput({tag, "_npc_valid"}, {31'd0, npc_valid}, 32'd1);
    checkOutput({tag, "_npc"}, npc, v.exp_npc);
    checkOutput({tag, "_npc_flush"}, {31'd0, npc_flush}, {31'd0, v.exp_flush});
    checkOutput({tag, "_redirect_rf_wen"}, {31'd0, rf_wen}, 32'd0);
    npc_ready = 1'b1;
    tick();
    npc_ready = 1'b0;
    checkOutput({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    csr_raddr = v.chk_addr;
    #1;
    checkOutput({tag, "_csr"}, csr_rdata, v.exp_csr);
  endtask

  initial begin
    // Fields: pc, result, reg_write, rd, csr_write, csr_addr, ecall, mret,
    // is_branch, target, fence_i | exp_wen, exp_waddr, exp_wdata, exp_npc,
    // exp_flush, chk_addr, exp_csr
    vecs[0] = '{32'h3000_0010, 32'hDEAD_BEEF, 1'b1, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0,
                1'b1, 4'd5, 32'hDEAD_BEEF, 32'h3000_0014, 1'b0, 2'd0, 32'h0000_1800};
    vecs[1] = '{32'h3000_0014, 32'h0000_1234, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h3000_0100, 1'b0,
                1'b0, 4'd0, 32'd0, 32'h3000_0100, 1'b0, 2'd1, 32'd0};
    vecs[2] = '{32'h3000_0100, 32'h3000_0800, 1'b0, 4'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0,
                1'b0, 4'd0, 32'd0, 32'h3000_0104, 1'b0, 2'd1, 32'h3000_0800};
    vecs[3] = '{32'h3000_0020, 32'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0,
                1'b0, 4'd0, 32'd0, 32'h3000_0800, 1'b0, 2'd2, 32'h3000_0020};
    vecs[4] = '{32'h3000_0800, 32'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0,
                1'b0, 4'd0, 32'd0, 32'h3000_0020, 1'b0, 2'd3, 32'd11};
    vecs[5] = '{32'h3000_0040, 32'h0000_0055, 1'b1, 4'd7, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0,
                1'b1, 4'd7, 32'h0000_0055, 32'h3000_0800, 1'b0, 2'd2, 32'h3000_0040};
    vecs[6] = '{32'h3000_0050, 32'h0000_0088, 1'b0, 4'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0,
                1'b0, 4'd0, 32'd0, 32'h3000_0800, 1'b0, 2'd0, 32'h0000_0088};
    vecs[7] = '{32'h3000_0800, 32'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0,
                1'b0, 4'd0, 32'd0, 32'h3000_0050, 1'b0, 2'd3, 32'd11};
    vecs[8] = '{32'hFFFF_FFFC, 32'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0,
                1'b0, 4'd0, 32'd0, 32'h0000_0000, 1'b0, 2'd2, 32'h3000_0050};

    clearInputs();
    npc_ready = 1'b0;
    csr_raddr = 2'd0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Boot: RESET_PC offered for cycles 0-3, fetch accepts in cycle 3.
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("boot_npc_valid_c%0d", c), {31'd0, npc_valid}, 32'd1);
      checkOutput($sformatf("boot_npc_c%0d", c), npc, RESET_PC);
      checkOutput($sformatf("boot_flush_c%0d", c), {31'd0, npc_flush}, 32'd0);
      checkOutput($sformatf("boot_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
      if (c == 3) npc_ready = 1'b1;
      tick();
    end
    npc_ready = 1'b0;
    checkOutput("boot_in_ready_c4", {31'd0, in_ready}, 32'd1);
    checkOutput("boot_npc_valid_c4", {31'd0, npc_valid}, 32'd0);
    checkOutput("boot_rf_wen", {31'd0, rf_wen}, 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

    // fence.i with fetch stalled for 5 cycles; in_valid pulses must be ignored.
    waitReady("fence");
    in_valid   = 1'b1;
    pc_in      = 32'h3000_0200;
    fence_i_in = 1'b1;
    tick();
    clearInputs();
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("fence_npc_valid_c%0d", c), {31'd0, npc_valid}, 32'd1);
      checkOutput($sformatf("fence_npc_c%0d", c), npc, 32'h3000_0204);
      checkOutput($sformatf("fence_flush_c%0d", c), {31'd0, npc_flush}, 32'd1);
      checkOutput($sformatf("fence_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
      in_valid = (c % 2 == 0) && (c != 4);
      pc_in    = 32'h1111_1110;
      tick();
    end
    clearInputs();
    checkOutput("fence_npc_after_stall", npc, 32'h3000_0204);
    npc_ready = 1'b1;
    tick();
    npc_ready = 1'b0;
    checkOutput("fence_idle_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("fence_idle_npc_valid", {31'd0, npc_valid}, 32'd0);

    // Reset landing in COMMIT of an rd=3 write plus an mtvec write.
    waitReady("rst_commit");
    in_valid     = 1'b1;
    pc_in        = 32'h3000_0300;
    result_in    = 32'h0000_0777;
    reg_write_in = 1'b1;
    rd_in        = 4'd3;
    csr_write_in = 1'b1;
    csr_addr_in  = 2'd1;
    tick();
    clearInputs();
    rst = 1'b1;
    #1;
    checkOutput("rst_commit_rf_wen", {31'd0, rf_wen}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_boot_npc_valid", {31'd0, npc_valid}, 32'd1);
    checkOutput("rst_boot_npc", npc, RESET_PC);
    checkOutput("rst_boot_flush", {31'd0, npc_flush}, 32'd0);
    checkOutput("rst_boot_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_boot_rf_wen", {31'd0, rf_wen}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      csr_raddr = 2'(a);
      #1;
      checkOutput($sformatf("rst_csr%0d", a), csr_rdata, (a == 0) ? 32'h0000_1800 : 32'd0);
    end
    tick();
    checkOutput("rst_boot_hold_npc_valid", {31'd0, npc_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
